// File: rtl/dsp_sched.sv
// dsp_sched: round-robin scheduler sharing one pipelined DSP among NREQ requesters.
// Grant, operand capture and dsp_start happen combinationally in the issue cycle.
// A configuration change ({mode,mac}) waits in DRAIN until the DSP pipe is empty.
// Define DSP_SCHED_STALL_CNT_EN to add the saturating stall_cnt output (DRAIN cycles).
module dsp_sched #(
    parameter int unsigned N    = 16,
    parameter int unsigned M    = 16,
    parameter int unsigned NREQ = 4,
    parameter int unsigned LAT0 = 2,
    parameter int unsigned LAT1 = 3,
    parameter int unsigned LAT2 = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [2*NREQ-1:0]        req_mode,
    input  logic [NREQ-1:0]          req_mac,
    input  logic [N*NREQ-1:0]        req_aa,
    input  logic [M*NREQ-1:0]        req_bb,
    input  logic [(N+M)*NREQ-1:0]    req_cc,
    output logic                     dsp_start,
    output logic                     dsp_mac,
    output logic [1:0]               dsp_mode,
    output logic [N-1:0]             dsp_aa,
    output logic [M-1:0]             dsp_bb,
    output logic [N+M-1:0]           dsp_cc,
    input  logic [N+M-1:0]           dsp_out,
    output logic                     resp_valid,
    output logic [2:0]               resp_id,
    output logic [N+M-1:0]           resp_data,
    output logic                     err_illegal
`ifdef DSP_SCHED_STALL_CNT_EN
    ,
    output logic [15:0]              stall_cnt
`endif
);

    typedef enum logic [1:0] {StIdle, StIssue, StHold, StDrain} state_e;

    localparam int unsigned IW = (LAT2 > 1) ? $clog2(LAT2) : 1;

    state_e           state_q, cur_state;
    logic [2:0]       ptr_q, drain_id_q;
    logic [1:0]       hold_q;
    logic [1:0]       mode_q;
    logic             mac_q;
    logic [N-1:0]     aa_q;
    logic [M-1:0]     bb_q;
    logic [N+M-1:0]   cc_q;

    logic [LAT2-1:0]  pipe_vld_q, pipe_vld_d;
    logic [2:0]       pipe_id_q [LAT2];
    logic [2:0]       pipe_id_d [LAT2];

    logic             rr_found;
    logic [2:0]       rr_win;
    logic             cand_vld;
    logic [2:0]       cand_id;
    logic [NREQ-1:0]  cand_oh;
    logic [1:0]       cand_mode;
    logic             cand_mac;
    logic [N-1:0]     cand_aa;
    logic [M-1:0]     cand_bb;
    logic [N+M-1:0]   cand_cc;
    logic             illegal, match, grant, issue, stall_wait;
    logic [IW-1:0]    lat_idx;

    // Round-robin pick, candidate selection and grant decision for this cycle.
    always_comb begin
        rr_found = 1'b0;
        rr_win   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!rr_found && req_valid[i] && (3'(i) >= ptr_q)) begin
                rr_found = 1'b1;
                rr_win   = 3'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!rr_found && req_valid[i]) begin
                rr_found = 1'b1;
                rr_win   = 3'(i);
            end
        end

        // In DRAIN the blocked winner keeps its claim; it is dropped if it deasserts.
        cand_vld = 1'b0;
        cand_id  = rr_win;
        if (state_q == StIdle) begin
            cand_vld = rr_found;
        end else if (state_q == StDrain) begin
            cand_id = drain_id_q;
            for (int i = 0; i < NREQ; i++) begin
                if (drain_id_q == 3'(i)) cand_vld = req_valid[i];
            end
        end

        cand_oh   = '0;
        cand_mode = '0;
        cand_mac  = 1'b0;
        cand_aa   = '0;
        cand_bb   = '0;
        cand_cc   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (cand_id == 3'(i)) begin
                cand_oh[i] = 1'b1;
                cand_mode  = req_mode[2*i +: 2];
                cand_mac   = req_mac[i];
                cand_aa    = req_aa[N*i +: N];
                cand_bb    = req_bb[M*i +: M];
                cand_cc    = req_cc[(N+M)*i +: (N+M)];
            end
        end

        illegal    = (cand_mode == 2'd3);
        match      = (cand_mode == mode_q) && (cand_mac == mac_q);
        grant      = !rst && cand_vld && (illegal || match || (pipe_vld_q == '0));
        issue      = grant && !illegal;
        stall_wait = !rst && cand_vld && !grant;
        cur_state  = issue ? StIssue : state_q;

        unique case (cand_mode)
            2'd0:    lat_idx = IW'(LAT0 - 1);
            2'd1:    lat_idx = IW'(LAT1 - 1);
            default: lat_idx = IW'(LAT2 - 1);
        endcase
    end

    // Tag pipeline: shift toward stage 0, insert a new tag LATm-1 stages up.
    always_comb begin
        pipe_vld_d = pipe_vld_q >> 1;
        for (int k = 0; k < LAT2 - 1; k++) pipe_id_d[k] = pipe_id_q[k + 1];
        pipe_id_d[LAT2-1] = '0;
        if (issue) begin
            pipe_vld_d[lat_idx] = 1'b1;
            pipe_id_d[lat_idx]  = cand_id;
        end
    end

    // Scheduler FSM, round-robin pointer and held DSP configuration/operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            drain_id_q <= '0;
            hold_q     <= '0;
            mode_q     <= '0;
            mac_q      <= 1'b0;
            aa_q       <= '0;
            bb_q       <= '0;
            cc_q       <= '0;
        end else begin
            if (grant) ptr_q <= (cand_id == 3'(NREQ - 1)) ? 3'd0 : cand_id + 3'd1;
            if (issue) begin
                mode_q <= cand_mode;
                mac_q  <= cand_mac;
                aa_q   <= cand_aa;
                bb_q   <= cand_bb;
                cc_q   <= cand_cc;
            end
            case (cur_state)
                StIssue: begin
                    // Occupancy 1/2/4: the issue cycle plus 0/1/3 HOLD cycles.
                    if (cand_mode == 2'd0) begin
                        state_q <= StIdle;
                    end else begin
                        state_q <= StHold;
                        hold_q  <= (cand_mode == 2'd1) ? 2'd0 : 2'd2;
                    end
                end
                StHold: begin
                    if (hold_q == 2'd0) state_q <= StIdle;
                    else hold_q <= hold_q - 2'd1;
                end
                StDrain: begin
                    if (!cand_vld || grant) state_q <= StIdle;
                end
                default: begin
                    if (stall_wait) begin
                        state_q    <= StDrain;
                        drain_id_q <= cand_id;
                    end
                end
            endcase
        end
    end

    // In-flight tag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld_q <= '0;
            for (int k = 0; k < LAT2; k++) pipe_id_q[k] <= '0;
        end else begin
            pipe_vld_q <= pipe_vld_d;
            pipe_id_q  <= pipe_id_d;
        end
    end

    assign req_ready   = grant ? cand_oh : '0;
    assign err_illegal = grant && illegal;
    assign dsp_start   = issue;
    assign dsp_mode    = issue ? cand_mode : mode_q;
    assign dsp_mac     = issue ? cand_mac  : mac_q;
    assign dsp_aa      = issue ? cand_aa   : aa_q;
    assign dsp_bb      = issue ? cand_bb   : bb_q;
    assign dsp_cc      = issue ? cand_cc   : cc_q;
    assign resp_valid  = pipe_vld_q[0];
    assign resp_id     = pipe_vld_q[0] ? pipe_id_q[0] : 3'd0;
    assign resp_data   = pipe_vld_q[0] ? dsp_out : '0;

`ifdef DSP_SCHED_STALL_CNT_EN
    logic [15:0] stall_q;

    // Saturating count of cycles spent in DRAIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if ((state_q == StDrain) && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule
